// File: rtl/ball_dispenser.sv
// Ball dispenser: queues requested balls, spins the motor once per ball, and
// confirms each one with a drop-sensor edge. A request is visible on pending the
// next cycle and the motor starts one cycle later. There is no backpressure:
// requests beyond 7 saturate and set sticky overflow.
module ball_dispenser #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] ice_cream_balls,
    input  logic       ball_drop,
    input  logic       clear_fault,
    output logic       motor_on,
    output logic       busy,
    output logic       fault,
    output logic       overflow,
    output logic [2:0] pending,
    output logic [7:0] dispensed_total
);

    localparam int TMAX = (MOTOR_CYCLES > TIMEOUT_CYCLES) ? MOTOR_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {IDLE, SPIN, WAIT_DROP, FAULT} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic          drop_prev;
    logic          drop_edge;
    logic          accept;
    logic [1:0]    add;
    logic [3:0]    sum;

    always_comb begin
        drop_edge = ball_drop & ~drop_prev;
        // Drops only count while a ball is actually being dispensed.
        accept    = drop_edge && (state == SPIN || state == WAIT_DROP);
        add       = (ice_cream_balls == 2'd3) ? 2'd0 : ice_cream_balls;
        sum       = {1'b0, pending} + {2'b00, add} - {3'b000, accept};
    end

    assign motor_on = (state == SPIN);
    assign busy     = (state != IDLE);
    assign fault    = (state == FAULT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            timer           <= '0;
            drop_prev       <= 1'b0;
            pending         <= 3'd0;
            dispensed_total <= 8'd0;
            overflow        <= 1'b0;
        end else begin
            drop_prev <= ball_drop;
            pending   <= (sum > 4'd7) ? 3'd7 : sum[2:0];
            if (clear_fault)
                overflow <= 1'b0;
            if (sum > 4'd7)
                overflow <= 1'b1;
            if (accept)
                dispensed_total <= dispensed_total + 8'd1;

            case (state)
                IDLE: begin
                    if (pending != 3'd0) begin
                        state <= SPIN;
                        timer <= '0;
                    end
                end
                SPIN: begin
                    timer <= timer + 1'b1;
                    if (accept) begin
                        state <= IDLE;
                    end else if (timer == TW'(MOTOR_CYCLES - 1)) begin
                        state <= WAIT_DROP;
                        timer <= '0;
                    end
                end
                WAIT_DROP: begin
                    timer <= timer + 1'b1;
                    if (accept)
                        state <= IDLE;
                    else if (timer == TW'(TIMEOUT_CYCLES - 1))
                        state <= FAULT;
                end
                FAULT: begin
                    if (clear_fault)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_dispenser.sv
// Directed bench for ball_dispenser: stimulus queues expected output snapshots,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_ball_dispenser;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] ice_cream_balls;
    logic       ball_drop;
    logic       clear_fault;
    logic       motor_on;
    logic       busy;
    logic       fault;
    logic       overflow;
    logic [2:0] pending;
    logic [7:0] dispensed_total;

    ball_dispenser #(.MOTOR_CYCLES(8), .TIMEOUT_CYCLES(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .ice_cream_balls (ice_cream_balls),
        .ball_drop       (ball_drop),
        .clear_fault     (clear_fault),
        .motor_on        (motor_on),
        .busy            (busy),
        .fault           (fault),
        .overflow        (overflow),
        .pending         (pending),
        .dispensed_total (dispensed_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          at;
        logic [14:0] v;   // {motor, busy, fault, overflow, pending[2:0], total[7:0]}
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every snapshot due in the current cycle.
    always @(negedge clk) begin
        logic [14:0] act;
        act = {motor_on, busy, fault, overflow, pending, dispensed_total};
        while (q.size() > 0 && q[0].at <= cyc) begin
            checks = checks + 1;
            if (q[0].at < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: snapshot missed (due cycle %0d, now %0d)", q[0].name, q[0].at, cyc);
            end else if (act !== q[0].v) begin
                errors = errors + 1;
                $display("FAIL %s: got m=%b b=%b f=%b o=%b p=%0d t=%0d, want m=%b b=%b f=%b o=%b p=%0d t=%0d",
                         q[0].name, act[14], act[13], act[12], act[11], act[10:8], act[7:0],
                         q[0].v[14], q[0].v[13], q[0].v[12], q[0].v[11], q[0].v[10:8], q[0].v[7:0]);
            end
            void'(q.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input string name, input logic m, input logic b, input logic f,
                              input logic o, input logic [2:0] p, input logic [7:0] t);
        exp_t e;
        e.name = name;
        e.at   = cyc;
        e.v    = {m, b, f, o, p, t};
        q.push_back(e);
    endtask

    initial begin
        int wait_cnt;
        reset = 1'b0; ice_cream_balls = 2'd0; ball_drop = 1'b0; clear_fault = 1'b0;
        step(2);
        reset = 1'b1;
        expect_now("reset", 0, 0, 0, 0, 3'd0, 8'd0);

        // One ball, drop on the third SPIN cycle.
        ice_cream_balls = 2'd1;
        step(1); ice_cream_balls = 2'd0;
        expect_now("t1_pend", 0, 0, 0, 0, 3'd1, 8'd0);
        step(1); expect_now("t1_spin1", 1, 1, 0, 0, 3'd1, 8'd0);
        step(1); expect_now("t1_spin2", 1, 1, 0, 0, 3'd1, 8'd0);
        step(1); expect_now("t1_spin3", 1, 1, 0, 0, 3'd1, 8'd0);
        ball_drop = 1'b1;
        step(1); ball_drop = 1'b0;
        expect_now("t1_done", 0, 0, 0, 0, 3'd0, 8'd1);
        step(1); expect_now("t1_idle", 0, 0, 0, 0, 3'd0, 8'd1);

        // Two balls, first drop four cycles into WAIT_DROP.
        ice_cream_balls = 2'd2;
        step(1); ice_cream_balls = 2'd0;
        expect_now("t2_pend", 0, 0, 0, 0, 3'd2, 8'd1);
        step(1); expect_now("t2_spin1", 1, 1, 0, 0, 3'd2, 8'd1);
        step(7); expect_now("t2_spin8", 1, 1, 0, 0, 3'd2, 8'd1);
        step(1); expect_now("t2_wait1", 0, 1, 0, 0, 3'd2, 8'd1);
        step(3); expect_now("t2_wait4", 0, 1, 0, 0, 3'd2, 8'd1);
        ball_drop = 1'b1;
        step(1); ball_drop = 1'b0;
        expect_now("t2_idle_gap", 0, 0, 0, 0, 3'd1, 8'd2);
        step(1); expect_now("t2_second_spin", 1, 1, 0, 0, 3'd1, 8'd2);

        // Request arrives in the same cycle the drop is accepted.
        ball_drop = 1'b1; ice_cream_balls = 2'd1;
        step(1); ball_drop = 1'b0; ice_cream_balls = 2'd0;
        expect_now("t5_add_dec", 0, 0, 0, 0, 3'd1, 8'd3);

        // Never drop: 8 SPIN + 16 WAIT_DROP then FAULT.
        step(1); expect_now("t3_spin1", 1, 1, 0, 0, 3'd1, 8'd3);
        step(7); expect_now("t3_spin8", 1, 1, 0, 0, 3'd1, 8'd3);
        step(1); expect_now("t3_wait1", 0, 1, 0, 0, 3'd1, 8'd3);
        step(15); expect_now("t3_wait16", 0, 1, 0, 0, 3'd1, 8'd3);
        step(1); expect_now("t3_fault", 0, 1, 1, 0, 3'd1, 8'd3);
        ball_drop = 1'b1;
        step(1); ball_drop = 1'b0;
        expect_now("fault_spurious_drop", 0, 1, 1, 0, 3'd1, 8'd3);

        // Accumulate while stalled until saturation.
        ice_cream_balls = 2'd2;
        step(3); expect_now("t4_at7", 0, 1, 1, 0, 3'd7, 8'd3);
        step(1); ice_cream_balls = 2'd0;
        expect_now("t4_overflow", 0, 1, 1, 1, 3'd7, 8'd3);
        clear_fault = 1'b1;
        step(1); clear_fault = 1'b0;
        expect_now("t4_cleared", 0, 0, 0, 0, 3'd7, 8'd3);
        step(1); expect_now("t4_retry_spin", 1, 1, 0, 0, 3'd7, 8'd3);

        // Reset in the middle of SPIN.
        reset = 1'b0;
        step(1); reset = 1'b1;
        expect_now("t6_reset_mid_spin", 0, 0, 0, 0, 3'd0, 8'd0);

        // Spurious drop in IDLE, then the ignored value 3.
        ball_drop = 1'b1;
        step(1); ball_drop = 1'b0;
        expect_now("t6_idle_drop", 0, 0, 0, 0, 3'd0, 8'd0);
        step(1); expect_now("t6_idle_after", 0, 0, 0, 0, 3'd0, 8'd0);
        ice_cream_balls = 2'd3;
        step(1); ice_cream_balls = 2'd0;
        expect_now("req3_ignored", 0, 0, 0, 0, 3'd0, 8'd0);
        step(1); expect_now("req3_stays_idle", 0, 0, 0, 0, 3'd0, 8'd0);

        wait_cnt = 0;
        while (q.size() > 0 && wait_cnt < 10) begin
            step(1);
            wait_cnt++;
        end
        if (q.size() > 0) begin
            errors = errors + q.size();
            checks = checks + q.size();
            $display("FAIL drain: %0d snapshots never compared, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ball_dispenser.md
Name: ball_dispenser

Overview:
- Downstream consumer of the ice-cream vending FSM's `ice_cream_balls` output.
- Queues requested balls and drives the dispenser motor one ball at a time.
- Confirms each ball through a drop sensor; watchdog timeout raises a sticky fault.
- Sits between the vending controller and the motor driver / drop sensor.

Parameters:
- MOTOR_CYCLES, 8, cycles `motor_on` is held high per ball attempt (>=1).
- TIMEOUT_CYCLES, 16, cycles waited after motor stop for a drop before fault (>=1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- ice_cream_balls  input  2  balls requested this cycle (0..2); nonzero for one cycle per vend.
- ball_drop  input  1  drop sensor, level; a rising edge = one ball delivered.
- clear_fault  input  1  leaves FAULT; also clears `overflow`.
- motor_on  output  1  motor drive.
- busy  output  1  high when the FSM is not IDLE.
- fault  output  1  high in FAULT.
- overflow  output  1  sticky; a request was truncated by saturation.
- pending  output  3  balls requested but not yet confirmed.
- dispensed_total  output  8  confirmed balls, wraps 255->0.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; pending=0, dispensed_total=0, overflow=0.
  - Internal timer=0; drop_prev=0.
  - Outputs after reset: motor_on=0, busy=0, fault=0.
- Edge detect: drop_edge = ball_drop & ~drop_prev; drop_prev <= ball_drop every cycle.
- Request accept:
  - Every cycle, add = ice_cream_balls, with value 3 treated as 0.
  - dec = 1 when drop_edge is accepted (see FSM), else 0.
  - pending_next = pending + add - dec, computed 4-bit wide, then saturated to 7.
  - If the unsaturated result > 7: overflow <= 1 (sticky).
  - Simultaneous add and dec are both applied in the same cycle.
- FSM states: IDLE, SPIN, WAIT_DROP, FAULT. Outputs are Moore: motor_on = (state==SPIN), busy = (state!=IDLE), fault = (state==FAULT).
- IDLE:
  - If registered pending > 0: go to SPIN, timer=0.
  - A request sampled at edge t makes pending nonzero after t; SPIN is entered at edge t+1; motor_on is high from cycle t+1.
- SPIN:
  - timer increments each cycle.
  - drop_edge: accept (dec=1, dispensed_total+1), go to IDLE.
  - Else if timer == MOTOR_CYCLES-1: go to WAIT_DROP, timer=0.
  - Without a drop, motor_on is high for exactly MOTOR_CYCLES cycles.
- WAIT_DROP:
  - Motor off; timer increments.
  - drop_edge: accept, go to IDLE.
  - Else if timer == TIMEOUT_CYCLES-1: go to FAULT.
- FAULT:
  - Motor off; pending is retained and requests are still accumulated.
  - clear_fault: go to IDLE (retry on the next cycle if pending > 0); overflow <= 0 on the same edge.
- A drop_edge in IDLE or FAULT is spurious: ignored, no counter change.
- Between consecutive balls there is always at least one IDLE cycle (motor_on low for >=1 cycle).
- clear_fault outside FAULT clears overflow only.
- Reset mid-SPIN: motor_on is low the cycle after the reset edge; queued requests are lost.

Test Plan:
- Reset, then ice_cream_balls=1 for one cycle, drop edge on the 3rd SPIN cycle:
  - pending 0->1; motor_on high for 3 cycles.
  - Then pending=0, dispensed_total=1, busy=0.
- ice_cream_balls=2, no drop during SPIN, drop 4 cycles into WAIT_DROP:
  - motor_on high 8 cycles; pending 2->1.
  - Second SPIN starts after one IDLE cycle.
- ice_cream_balls=1, never drop:
  - 8 SPIN + 16 WAIT_DROP cycles, then fault=1, motor_on=0, pending=1.
  - clear_fault pulse -> IDLE, then SPIN retry.
- Four consecutive requests of 2 while stalled:
  - pending saturates at 7, overflow=1.
  - clear_fault sets overflow=0.
- ice_cream_balls=1 on the same cycle a drop is accepted with pending=1:
  - pending stays 1; dispensed_total increments.
- ball_drop pulses in IDLE; reset asserted mid-SPIN:
  - No counter change; after reset all outputs 0, pending=0.
